// File: rtl/icache_refill_master.sv
// icache_refill_master: fetches one LINE_WORDS-word cache line over the
// CEN/A/GNT/RVAL/Q memory port and hands it to the refill logic.
module icache_refill_master #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    // refill request side
    input  logic                             refill_req_i,
    input  logic [ADDR_WIDTH-1:0]            refill_addr_i,
    output logic                             refill_gnt_o,
    // assembled line side
    output logic                             line_valid_o,
    output logic [ADDR_WIDTH-1:0]            line_addr_o,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] line_data_o,
    input  logic                             line_ready_i,
    output logic                             err_o,
    // memory port
    output logic                             CEN,
    output logic [ADDR_WIDTH-1:0]            A,
    input  logic                             GNT,
    output logic                             WEN,
    output logic [DATA_WIDTH-1:0]            D,
    output logic [BE_WIDTH-1:0]              BE,
    input  logic [DATA_WIDTH-1:0]            Q,
    input  logic                             RVAL
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        issue_q, issue_d;
    logic [CNT_W-1:0]        rsp_q, rsp_d;
    logic [CNT_W-1:0]        outstanding;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [DATA_WIDTH-1:0]   buf_q [LINE_WORDS];
    logic                    rsp_take;
    logic                    err_d;
    logic                    cen_d;
    logic [ADDR_WIDTH-1:0]   a_d;
    logic                    gnt_d;
    logic                    valid_d;

    // Read-only port: write controls are tied off.
    assign WEN = 1'b1;
    assign D   = '0;
    assign BE  = '1;

    assign line_addr_o = base_q;

    // Flatten the line buffer onto the output bus, word k at k*DATA_WIDTH.
    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_pack
        assign line_data_o[k*DATA_WIDTH +: DATA_WIDTH] = buf_q[k];
    end

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        issue_d     = issue_q;
        rsp_d       = rsp_q;
        base_d      = base_q;
        err_d       = err_o;
        outstanding = issue_q - rsp_q;
        rsp_take    = 1'b0;

        // Responses are only meaningful while a line is in flight.
        if (RVAL && (state_q != IDLE)) begin
            if (((state_q == ISSUE) || (state_q == WAIT)) && (outstanding != '0)) begin
                rsp_take = 1'b1;
                rsp_d    = rsp_q + CNT_W'(1);
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (refill_req_i) begin
                    base_d  = refill_addr_i & ~ADDR_WIDTH'(LINE_WORDS - 1);
                    issue_d = '0;
                    rsp_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (GNT) begin
                    issue_d = issue_q + CNT_W'(1);
                    if (issue_q == CNT_W'(LINE_WORDS - 1)) begin
                        state_d = (rsp_d == CNT_W'(LINE_WORDS)) ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                if (rsp_d == CNT_W'(LINE_WORDS)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (line_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cen_d   = (state_d != ISSUE);
        a_d     = (state_d == ISSUE) ? (base_d | ADDR_WIDTH'(issue_d[IDX_W-1:0])) : '0;
        gnt_d   = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    // State, counters, line buffer and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            issue_q      <= '0;
            rsp_q        <= '0;
            base_q       <= '0;
            err_o        <= 1'b0;
            CEN          <= 1'b1;
            A            <= '0;
            refill_gnt_o <= 1'b1;
            line_valid_o <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            issue_q      <= issue_d;
            rsp_q        <= rsp_d;
            base_q       <= base_d;
            err_o        <= err_d;
            CEN          <= cen_d;
            A            <= a_d;
            refill_gnt_o <= gnt_d;
            line_valid_o <= valid_d;
            if (rsp_take) begin
                buf_q[rsp_q[IDX_W-1:0]] <= Q;
            end
        end
    end

endmodule
